store_commit_unit: RTL and testbench

STORE_COMMIT_UNIT -- requirements
Module: store_commit_unit

---
 rtl/store_commit_unit.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_store_commit_unit.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_commit_unit.sv
// -----------------------------------------------------------------------------
// store_commit_unit
//
// Retires committed stores from the head of the ROB into a small circular
// store queue, then drains the queue into the data memory one write at a time.
// Each store is converted to a word address, a byte-lane mask and
// lane-replicated write data at acceptance time. Illegal or misaligned stores
// are still accepted so the ROB is never blocked, but they are dropped and
// raise a sticky error flag.
//
// A three-state FSM (IDLE -> WRITE -> HOLD -> IDLE) pops one entry into an
// in-flight register, strobes memory for one cycle, then waits out the
// remaining memory latency before the next pop.
//
// Ports
//   clk_in            : single clock, all state on posedge
//   rst_in            : synchronous, active-high reset
//   store_valid_in    : ROB head holds a ready store
//   store_value_in    : store data at ROB head
//   store_addr_in     : effective byte address at ROB head
//   store_funct3_in   : size (000=SB, 001=SH, 010=SW)
//   store_read_out    : accept strobe; ROB pops its head on this edge
//   load_addr_in      : byte address of a load checking for a conflict
//   load_conflict_out : a queued or in-flight store targets the same word
//   mem_en_out        : data-memory write strobe
//   mem_we_out        : byte-lane write mask
//   mem_addr_out      : word address
//   mem_wdata_out     : lane-replicated write data
//   count_out         : queued entries (in-flight entry not included)
//   empty_out         : queue empty and FSM idle
//   misalign_err_out  : sticky illegal/misaligned store flag
// -----------------------------------------------------------------------------
module store_commit_unit #(
    parameter int DEPTH         = 4,
    parameter int WRITE_LATENCY = 2,
    parameter int ADDR_W        = 16
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     store_valid_in,
    input  logic [31:0]              store_value_in,
    input  logic [31:0]              store_addr_in,
    input  logic [2:0]               store_funct3_in,
    output logic                     store_read_out,
    input  logic [31:0]              load_addr_in,
    output logic                     load_conflict_out,
    output logic                     mem_en_out,
    output logic [3:0]               mem_we_out,
    output logic [ADDR_W-1:0]        mem_addr_out,
    output logic [31:0]              mem_wdata_out,
    output logic [$clog2(DEPTH):0]   count_out,
    output logic                     empty_out,
    output logic                     misalign_err_out
);

    localparam int PTR_W     = $clog2(DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    // HOLD lasts WRITE_LATENCY-1 cycles; the counter runs 0..WRITE_LATENCY-2.
    localparam int HOLD_W    = (WRITE_LATENCY > 1) ? $clog2(WRITE_LATENCY) : 1;
    localparam int HOLD_LAST = (WRITE_LATENCY > 1) ? (WRITE_LATENCY - 2) : 0;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // ---------------------------------------------------------------- helpers

    // Size/alignment legality of a store.
    function automatic logic store_legal(input logic [2:0] f3, input logic [1:0] a);
        logic ok;
        case (f3)
            F3_SB:   ok = 1'b1;
            F3_SH:   ok = (a[0] == 1'b0);
            F3_SW:   ok = (a == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte-lane mask for a legal store.
    function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] m;
        case (f3)
            F3_SB:   m = 4'b0001 << a;
            F3_SH:   m = a[1] ? 4'b1100 : 4'b0011;
            F3_SW:   m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Write data replicated across the lanes the store may occupy.
    function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] v);
        logic [31:0] d;
        case (f3)
            F3_SB:   d = {4{v[7:0]}};
            F3_SH:   d = {2{v[15:0]}};
            F3_SW:   d = v;
            default: d = 32'h0000_0000;
        endcase
        return d;
    endfunction

    // ---------------------------------------------------------------- storage

    logic [ADDR_W-1:0] q_addr_r [DEPTH];
    logic [3:0]        q_mask_r [DEPTH];
    logic [31:0]       q_data_r [DEPTH];
    logic [DEPTH-1:0]  q_valid_r;

    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [CNT_W-1:0]  count_r;

    logic [ADDR_W-1:0] infl_addr_r;
    logic [3:0]        infl_mask_r;
    logic [31:0]       infl_data_r;

    state_t            state_r;
    state_t            state_next_s;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic              misalign_r;

    logic              accept_s;
    logic              legal_s;
    logic              enq_s;
    logic              deq_s;
    logic [ADDR_W-1:0] store_word_s;
    logic [ADDR_W-1:0] load_word_s;
    logic              conflict_s;
    logic              unused_s;

    // ---------------------------------------------------------------- handshake

    // Full blocks acceptance even if the FSM pops this cycle, keeping the
    // accept path independent of the drain path.
    assign accept_s     = store_valid_in && (count_r < CNT_W'(DEPTH)) && !rst_in;
    assign legal_s      = store_legal(store_funct3_in, store_addr_in[1:0]);
    assign enq_s        = accept_s && legal_s;
    assign deq_s        = (state_r == ST_IDLE) && (count_r != CNT_W'(0));
    assign store_word_s = store_addr_in[ADDR_W+1:2];
    assign load_word_s  = load_addr_in[ADDR_W+1:2];

    assign store_read_out   = accept_s;
    assign count_out        = count_r;
    assign empty_out        = (count_r == CNT_W'(0)) && (state_r == ST_IDLE);
    assign misalign_err_out = misalign_r;
    assign mem_addr_out     = infl_addr_r;
    assign mem_wdata_out    = infl_data_r;

    // Upper address bits beyond the memory range and the load byte offset are
    // intentionally ignored.
    assign unused_s = ^{store_addr_in, load_addr_in};

    // Queue pointers, occupancy, entry valid bits and the sticky error flag.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_r     <= PTR_W'(0);
            tail_r     <= PTR_W'(0);
            count_r    <= CNT_W'(0);
            q_valid_r  <= {DEPTH{1'b0}};
            misalign_r <= 1'b0;
        end else begin
            if (deq_s) begin
                q_valid_r[head_r] <= 1'b0;
                head_r            <= head_r + PTR_W'(1);
            end
            // tail never equals head here: enq needs count<DEPTH, deq needs count>0
            if (enq_s) begin
                q_valid_r[tail_r] <= 1'b1;
                tail_r            <= tail_r + PTR_W'(1);
            end
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            if (accept_s && !legal_s) begin
                misalign_r <= 1'b1;
            end
        end
    end

    // Queue payload and in-flight register; contents are qualified by the
    // valid bits and the FSM state, so no reset is needed.
    always_ff @(posedge clk_in) begin
        if (enq_s) begin
            q_addr_r[tail_r] <= store_word_s;
            q_mask_r[tail_r] <= lane_mask(store_funct3_in, store_addr_in[1:0]);
            q_data_r[tail_r] <= lane_data(store_funct3_in, store_value_in);
        end
        if (deq_s) begin
            infl_addr_r <= q_addr_r[head_r];
            infl_mask_r <= q_mask_r[head_r];
            infl_data_r <= q_data_r[head_r];
        end
    end

    // ---------------------------------------------------------------- FSM

    // FSM state register and HOLD cycle counter.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r    <= ST_IDLE;
            hold_cnt_r <= HOLD_W'(0);
        end else begin
            state_r <= state_next_s;
            if (state_r == ST_WRITE) begin
                hold_cnt_r <= HOLD_W'(0);
            end else if (state_r == ST_HOLD) begin
                hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
            end else begin
                hold_cnt_r <= hold_cnt_r;
            end
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (count_r != CNT_W'(0)) begin
                    state_next_s = ST_WRITE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (WRITE_LATENCY > 1) begin
                    state_next_s = ST_HOLD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_r == HOLD_W'(HOLD_LAST)) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs: memory strobe and lane mask only in WRITE.
    always_comb begin
        mem_en_out = 1'b0;
        mem_we_out = 4'b0000;
        case (state_r)
            ST_WRITE: begin
                mem_en_out = 1'b1;
                mem_we_out = infl_mask_r;
            end
            default: begin
                mem_en_out = 1'b0;
                mem_we_out = 4'b0000;
            end
        endcase
    end

    // ---------------------------------------------------------------- conflict

    // Load/store word conflict against valid queue entries and the in-flight
    // write; a store being accepted this same cycle is not considered.
    always_comb begin
        conflict_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_valid_r[i] && (q_addr_r[i] == load_word_s)) begin
                conflict_s = 1'b1;
            end else begin
                conflict_s = conflict_s;
            end
        end
        if (((state_r == ST_WRITE) || (state_r == ST_HOLD)) && (infl_addr_r == load_word_s)) begin
            conflict_s = 1'b1;
        end else begin
            conflict_s = conflict_s;
        end
    end

    assign load_conflict_out = conflict_s;

endmodule

// File: tb/tb_store_commit_unit.sv
// -----------------------------------------------------------------------------
// tb_store_commit_unit
//
// Directed stimulus with hand-computed expected memory writes. Every legal
// store pushes its expected {word addr, mask, data} into a scoreboard queue;
// a monitor thread pops and compares on every memory strobe, and also checks
// strobe spacing. Inline checks cover handshake, occupancy, conflict, error
// flag and reset behaviour.
// -----------------------------------------------------------------------------
module tb_store_commit_unit;

    localparam int DEPTH = 4;
    localparam int WL    = 2;
    localparam int AW    = 16;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [3:0]    we;
        logic [31:0]   data;
    } wr_t;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          store_valid_in;
    logic [31:0]   store_value_in;
    logic [31:0]   store_addr_in;
    logic [2:0]    store_funct3_in;
    logic          store_read_out;
    logic [31:0]   load_addr_in;
    logic          load_conflict_out;
    logic          mem_en_out;
    logic [3:0]    mem_we_out;
    logic [AW-1:0] mem_addr_out;
    logic [31:0]   mem_wdata_out;
    logic [2:0]    count_out;
    logic          empty_out;
    logic          misalign_err_out;

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks          = 0;
    int  errors          = 0;
    int  cyc             = 0;
    int  strobe_cnt      = 0;
    int  last_strobe_cyc = 0;
    int  burst_base      = 0;
    bit  exact_mode      = 1'b0;
    bit  mon_on          = 1'b0;
    int  k;

    bit acc_tab [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int cnt_tab [12] = '{0, 1, 1, 2, 3, 3, 4, 4, 3, 4, 4, 3};

    store_commit_unit #(.DEPTH(DEPTH), .WRITE_LATENCY(WL), .ADDR_W(AW)) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .store_valid_in    (store_valid_in),
        .store_value_in    (store_value_in),
        .store_addr_in     (store_addr_in),
        .store_funct3_in   (store_funct3_in),
        .store_read_out    (store_read_out),
        .load_addr_in      (load_addr_in),
        .load_conflict_out (load_conflict_out),
        .mem_en_out        (mem_en_out),
        .mem_we_out        (mem_we_out),
        .mem_addr_out      (mem_addr_out),
        .mem_wdata_out     (mem_wdata_out),
        .count_out         (count_out),
        .empty_out         (empty_out),
        .misalign_err_out  (misalign_err_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_in);
        #1;
    endtask

    // Offer one store for a single cycle; it must be accepted.
    task automatic send(input string nm, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] v, input bit push, input wr_t e);
        store_valid_in  = 1'b1;
        store_funct3_in = f3;
        store_addr_in   = a;
        store_value_in  = v;
        @(negedge clk_in);
        chk({nm, "_accept"}, {31'd0, store_read_out}, 32'd1);
        if (push) exp_q.push_back(e);
        next_cycle();
        store_valid_in = 1'b0;
    endtask

    // Wait (bounded) until the unit is idle and every expected write was seen.
    task automatic wait_empty(input string nm, input int budget);
        int n;
        n = 0;
        while ((n < budget) && !(empty_out && (exp_q.size() == 0))) begin
            @(negedge clk_in);
            n++;
        end
        chk({nm, "_drained"}, {31'd0, (empty_out && (exp_q.size() == 0))}, 32'd1);
        next_cycle();
    endtask

    initial begin
        rst_in          = 1'b1;
        store_valid_in  = 1'b0;
        store_value_in  = 32'h0;
        store_addr_in   = 32'h0;
        store_funct3_in = 3'b010;
        load_addr_in    = 32'h0;

        fork
            begin
                forever begin
                    @(posedge clk_in);
                    cyc++;
                end
            end
            begin
                forever begin
                    @(negedge clk_in);
                    if (mon_on) begin
                        if (mem_en_out) begin
                            if (strobe_cnt > 0) begin
                                chk("strobe_gap_min", {31'd0, ((cyc - last_strobe_cyc) >= (WL + 1))}, 32'd1);
                            end
                            if (exact_mode && (strobe_cnt > burst_base)) begin
                                chk("burst_gap", cyc - last_strobe_cyc, WL + 1);
                            end
                            last_strobe_cyc = cyc;
                            strobe_cnt++;
                            if (exp_q.size() == 0) begin
                                checks++;
                                errors++;
                                $display("FAIL unexpected_strobe: got addr 0x%04h we %b, want no strobe",
                                         mem_addr_out, mem_we_out);
                            end else begin
                                mon_e = exp_q.pop_front();
                                chk("wr_addr", {16'd0, mem_addr_out}, {16'd0, mon_e.addr});
                                chk("wr_we", {28'd0, mem_we_out}, {28'd0, mon_e.we});
                                chk("wr_data", mem_wdata_out, mon_e.data);
                            end
                        end else begin
                            chk("idle_we", {28'd0, mem_we_out}, 32'd0);
                        end
                    end
                end
            end
        join_none

        // Reset: no acceptance while rst_in is high, then clean state.
        next_cycle();
        store_valid_in = 1'b1;
        store_addr_in  = 32'h10;
        @(negedge clk_in);
        chk("rst_read", {31'd0, store_read_out}, 32'd0);
        next_cycle();
        rst_in         = 1'b0;
        store_valid_in = 1'b0;
        load_addr_in   = 32'h10;
        mon_on         = 1'b1;
        @(negedge clk_in);
        chk("rst_count", {29'd0, count_out}, 32'd0);
        chk("rst_empty", {31'd0, empty_out}, 32'd1);
        chk("rst_en", {31'd0, mem_en_out}, 32'd0);
        chk("rst_err", {31'd0, misalign_err_out}, 32'd0);
        chk("rst_conflict", {31'd0, load_conflict_out}, 32'd0);
        next_cycle();

        // SW to word 4: pop cycle, WRITE, HOLD, and load conflict tracking.
        send("sw", 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, '{16'h0004, 4'b1111, 32'hDEAD_BEEF});
        load_addr_in = 32'h11;
        @(negedge clk_in);
        chk("q_count", {29'd0, count_out}, 32'd1);
        chk("q_empty", {31'd0, empty_out}, 32'd0);
        chk("q_pop_no_en", {31'd0, mem_en_out}, 32'd0);
        chk("q_conflict_hit", {31'd0, load_conflict_out}, 32'd1);
        load_addr_in = 32'h14;
        #1;
        chk("q_conflict_miss", {31'd0, load_conflict_out}, 32'd0);
        next_cycle();
        load_addr_in = 32'h11;
        @(negedge clk_in);
        chk("w_en", {31'd0, mem_en_out}, 32'd1);
        chk("w_conflict", {31'd0, load_conflict_out}, 32'd1);
        next_cycle();
        @(negedge clk_in);
        chk("h_conflict", {31'd0, load_conflict_out}, 32'd1);
        next_cycle();
        @(negedge clk_in);
        chk("done_conflict", {31'd0, load_conflict_out}, 32'd0);
        chk("done_empty", {31'd0, empty_out}, 32'd1);
        next_cycle();

        // Byte and halfword lanes.
        send("sb_hi", 3'b000, 32'h13, 32'h0000_00A5, 1'b1, '{16'h0004, 4'b1000, 32'hA5A5_A5A5});
        send("sh_hi", 3'b001, 32'h12, 32'h0000_1234, 1'b1, '{16'h0004, 4'b1100, 32'h1234_1234});
        send("sb_lo", 3'b000, 32'h40, 32'hFFFF_FF5A, 1'b1, '{16'h0010, 4'b0001, 32'h5A5A_5A5A});
        send("sh_lo", 3'b001, 32'h44, 32'hFFFF_BEEF, 1'b1, '{16'h0011, 4'b0011, 32'hBEEF_BEEF});
        wait_empty("lanes", 40);

        // Held-valid burst: fill to full, back-pressure, pointer wrap.
        exact_mode = 1'b1;
        burst_base = strobe_cnt;
        k          = 0;
        for (int c = 0; c < 12; c++) begin
            store_valid_in  = 1'b1;
            store_funct3_in = 3'b010;
            store_addr_in   = 32'h200 + 32'(4 * k);
            store_value_in  = 32'hB000_0000 + 32'(k);
            @(negedge clk_in);
            chk($sformatf("burst_read_%0d", c), {31'd0, store_read_out}, {31'd0, acc_tab[c]});
            chk($sformatf("burst_count_%0d", c), {29'd0, count_out}, 32'(cnt_tab[c]));
            if (acc_tab[c]) begin
                exp_q.push_back('{AW'(16'h0080 + k), 4'b1111, 32'hB000_0000 + 32'(k)});
                k++;
            end
            next_cycle();
        end
        store_valid_in = 1'b0;
        wait_empty("burst", 60);
        exact_mode = 1'b0;

        // Illegal stores: accepted, dropped, sticky error.
        send("sw_mis", 3'b010, 32'h06, 32'h1111_1111, 1'b0, '0);
        @(negedge clk_in);
        chk("mis_err", {31'd0, misalign_err_out}, 32'd1);
        chk("mis_count", {29'd0, count_out}, 32'd0);
        chk("mis_empty", {31'd0, empty_out}, 32'd1);
        next_cycle();
        send("sh_odd", 3'b001, 32'h21, 32'h2222_2222, 1'b0, '0);
        send("bad_f3", 3'b011, 32'h30, 32'h3333_3333, 1'b0, '0);
        send("sw_ok", 3'b010, 32'h20, 32'hCAFE_F00D, 1'b1, '{16'h0008, 4'b1111, 32'hCAFE_F00D});
        wait_empty("mis", 30);
        @(negedge clk_in);
        chk("mis_sticky", {31'd0, misalign_err_out}, 32'd1);
        next_cycle();

        // Reset during HOLD with two entries queued.
        send("r1", 3'b010, 32'h50, 32'h0101_0101, 1'b1, '{16'h0014, 4'b1111, 32'h0101_0101});
        send("r2", 3'b010, 32'h54, 32'h0202_0202, 1'b0, '0);
        send("r3", 3'b010, 32'h58, 32'h0303_0303, 1'b0, '0);
        rst_in          = 1'b1;
        store_valid_in  = 1'b1;
        store_funct3_in = 3'b010;
        store_addr_in   = 32'h5C;
        load_addr_in    = 32'h54;
        @(negedge clk_in);
        chk("rh_read", {31'd0, store_read_out}, 32'd0);
        chk("rh_count", {29'd0, count_out}, 32'd2);
        chk("rh_conflict", {31'd0, load_conflict_out}, 32'd1);
        next_cycle();
        rst_in         = 1'b0;
        store_valid_in = 1'b0;
        @(negedge clk_in);
        chk("ra_count", {29'd0, count_out}, 32'd0);
        chk("ra_empty", {31'd0, empty_out}, 32'd1);
        chk("ra_err", {31'd0, misalign_err_out}, 32'd0);
        chk("ra_conflict", {31'd0, load_conflict_out}, 32'd0);
        repeat (8) @(negedge clk_in);
        chk("sb_leftover", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
